noc_nxn: RTL and testbench
==========================

# noc_nxn

4x4 mesh network-on-chip with 16 nodes. Each node has a local injection port carrying operands A/B and a destination K, a one-flit injection buffer, a router, and a registered ejection port. Each node turns its local inputs into single-flit 32-bit packets and routes them dimension-ordered (X then Y) to the destination node. There, the packet is presented on that node's `router_out`. This block is the top-level fabric; traffic sources and sinks connect per node.

## Interface
- Parameter `BUS_WIDTH`, default 32: flit and `router_out` width. The flit format below requires 32.
- Clocking: one clock, `clk1`. Reset `rst` is synchronous and active-high.
- `clk1`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `Arc`  in  8  operand A of node at row r, column c (r,c ∈ 0..3).
- `Brc`  in  8  operand B of node rc.
- `Krc`  in  4  destination node id: K[3:2] = row, K[1:0] = column.
- `buffer_inrc`  in  1  local sink busy. 1 = node rc must not eject this cycle.
- `buffer_outrc`  out  1  injection buffer full. 1 = Arc/Brc/Krc are not sampled.
- `router_outrc`  out  BUS_WIDTH  flit ejected at node rc this cycle, else 0.

## Operation
- Node id is {row[1:0], col[1:0]}. Row 0 is north; column 0 is west.
- Flit format:
  - [31] valid
  - [30:27] source id
  - [26:23] destination (= K)
  - [22:16] zero
  - [15:8] A
  - [7:0] B
- Injection: on each edge with rst=0 and `buffer_out`=0, the node captures {1, own id, K, 7'b0, A, B} into its local input buffer. `buffer_out` equals that buffer's full flag. Injection is continuous; there is no separate valid input.
- Router structure: 5 input buffers (N, S, E, W, Local), each holding one flit, and 5 outputs (N, S, E, W, Local). Ports on the mesh edge are never used.
- XY routing:
  - If dst col > own col, route E; if less, route W.
  - Otherwise, if dst row > own row, route S; if less, route N.
  - Otherwise route to Local.
- Arbitration: per output, round-robin among requesting inputs. The pointer moves to the input after the winner.
- A grant to a neighbour output is allowed only if the neighbour's receiving input buffer is empty at the start of the cycle. There is no same-cycle bypass.
- A grant to Local is allowed only if `buffer_in`=0.
- A granted flit moves on the edge. The source buffer empties; the destination buffer fills.
- Ejection: `router_out` <= the granted flit if Local is granted this cycle, else 0.
- Self-addressed flits (K = own id) eject at the same node.
- No flit is dropped, duplicated or reordered between the same source/destination pair.

## Timing
- Reset: all buffers empty, all arbiter pointers 0, every `router_out`=0, every `buffer_out`=0. No capture occurs while rst=1.
- rst asserted mid-operation: all in-flight flits are discarded on that edge.
- Injection capture at edge n: `buffer_out`=1 after edge n.
- Uncontended latency for Manhattan distance d: flit on destination `router_out` after edge n+1+d, valid for exactly one cycle.
- `buffer_out` clears after the edge on which the local flit is granted. The next capture happens on the following edge, so uncontended steady-state injection rate is one flit per 2 cycles.
- Per-link throughput: at most one flit per 2 cycles, because the receiving buffer must be empty at cycle start.
- `buffer_in`=1 stalls Local ejection. Flits back up hop by hop, and upstream `buffer_out` rises once paths are full.
- Simultaneous requests for one output: exactly one grant per cycle. Every waiting input is served within 5 grants.

## Test plan
- **Reset:** rst=1 for 2 edges with random inputs → all 16 `router_out`=0 and all `buffer_out`=0; no flit is ever ejected for samples taken during reset.
- **Self delivery:** every node sets K = own id; node 00 uses A=8'h12, B=8'h34 → `router_out00`=32'h8000_1234 one edge after capture, then every 2 cycles.
- **Corner to corner:** node 00 sends K=4'hF, A=8'hAB, B=8'hCD; all other nodes self-addressed → `router_out33`=32'h8780_ABCD within 10 cycles of capture.
  - Path: E along row 0 to column 3, then S to row 3.
  - Payload arrives intact; source field = 0.
- **Hotspot with stall:** all nodes send K=4'h6; `buffer_in12`=1 for 30 cycles → `router_out12` stays 0 and all `buffer_out` reach 1.
  - Release `buffer_in12` → deliveries resume.
  - Per-source counts of ejected flits match the injected counts, with no loss and no duplicates.
- **Fairness:** nodes 02, 11 and 13 all send to 12 continuously → each source appears at `router_out12` at least once per 15 ejections.
- **Random traffic:** random A/B/K, 1000 cycles, scoreboarded → every captured flit is ejected exactly once at node K with unchanged A/B/source, and per-pair order is preserved.

Source files
------------

// File: rtl/noc_nxn.sv
// 4x4 mesh network-on-chip: per-node one-flit injection buffer, XY-routed single-flit
// packets, round-robin arbitration per router output and a registered ejection port.
module noc_nxn #(
  parameter int unsigned BUS_WIDTH = 32
) (
  input  logic                 clk1,
  input  logic                 rst,
  input  logic [7:0]           A00, A01, A02, A03, A10, A11, A12, A13,
                               A20, A21, A22, A23, A30, A31, A32, A33,
  input  logic [7:0]           B00, B01, B02, B03, B10, B11, B12, B13,
                               B20, B21, B22, B23, B30, B31, B32, B33,
  input  logic [3:0]           K00, K01, K02, K03, K10, K11, K12, K13,
                               K20, K21, K22, K23, K30, K31, K32, K33,
  input  logic                 buffer_in00, buffer_in01, buffer_in02, buffer_in03,
                               buffer_in10, buffer_in11, buffer_in12, buffer_in13,
                               buffer_in20, buffer_in21, buffer_in22, buffer_in23,
                               buffer_in30, buffer_in31, buffer_in32, buffer_in33,
  output logic                 buffer_out00, buffer_out01, buffer_out02, buffer_out03,
                               buffer_out10, buffer_out11, buffer_out12, buffer_out13,
                               buffer_out20, buffer_out21, buffer_out22, buffer_out23,
                               buffer_out30, buffer_out31, buffer_out32, buffer_out33,
  output logic [BUS_WIDTH-1:0] router_out00, router_out01, router_out02, router_out03,
                               router_out10, router_out11, router_out12, router_out13,
                               router_out20, router_out21, router_out22, router_out23,
                               router_out30, router_out31, router_out32, router_out33
);

  localparam int unsigned NODES = 16;
  localparam int unsigned PORTS = 5;
  localparam logic [2:0] P_N = 3'd0;
  localparam logic [2:0] P_S = 3'd1;
  localparam logic [2:0] P_E = 3'd2;
  localparam logic [2:0] P_W = 3'd3;
  localparam logic [2:0] P_L = 3'd4;

  typedef struct packed {
    logic       valid;
    logic [3:0] src;
    logic [3:0] dst;
    logic [6:0] zero;
    logic [7:0] a;
    logic [7:0] b;
  } flit_t;

  logic [7:0] a_in      [NODES];
  logic [7:0] b_in      [NODES];
  logic [3:0] k_in      [NODES];
  logic       sink_busy [NODES];

  flit_t      buf_q     [NODES][PORTS];
  flit_t      buf_d     [NODES][PORTS];
  logic [2:0] ptr_q     [NODES][PORTS];
  logic [2:0] ptr_d     [NODES][PORTS];
  flit_t      eject_q   [NODES];
  flit_t      eject_d   [NODES];

  logic       out_ok    [NODES][PORTS];
  logic       gnt_valid [NODES][PORTS];
  logic [2:0] gnt_in    [NODES][PORTS];

  assign a_in = '{A00, A01, A02, A03, A10, A11, A12, A13,
                  A20, A21, A22, A23, A30, A31, A32, A33};
  assign b_in = '{B00, B01, B02, B03, B10, B11, B12, B13,
                  B20, B21, B22, B23, B30, B31, B32, B33};
  assign k_in = '{K00, K01, K02, K03, K10, K11, K12, K13,
                  K20, K21, K22, K23, K30, K31, K32, K33};
  assign sink_busy = '{buffer_in00, buffer_in01, buffer_in02, buffer_in03,
                       buffer_in10, buffer_in11, buffer_in12, buffer_in13,
                       buffer_in20, buffer_in21, buffer_in22, buffer_in23,
                       buffer_in30, buffer_in31, buffer_in32, buffer_in33};

  // Dimension-ordered route: fix the column first, then the row.
  function automatic logic [2:0] route(input logic [3:0] self_id, input logic [3:0] dst);
    logic [2:0] p;
    if (dst[1:0] > self_id[1:0])      p = P_E;
    else if (dst[1:0] < self_id[1:0]) p = P_W;
    else if (dst[3:2] > self_id[3:2]) p = P_S;
    else if (dst[3:2] < self_id[3:2]) p = P_N;
    else                              p = P_L;
    return p;
  endfunction

  function automatic logic has_nb(input logic [3:0] id, input logic [2:0] o);
    logic r;
    case (o)
      P_N:     r = (id[3:2] != 2'd0);
      P_S:     r = (id[3:2] != 2'd3);
      P_E:     r = (id[1:0] != 2'd3);
      P_W:     r = (id[1:0] != 2'd0);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Wraps modulo 16; only meaningful where has_nb() is true.
  function automatic logic [3:0] nb_node(input logic [3:0] id, input logic [2:0] o);
    logic [3:0] r;
    case (o)
      P_N:     r = id - 4'd4;
      P_S:     r = id + 4'd4;
      P_E:     r = id + 4'd1;
      P_W:     r = id - 4'd1;
      default: r = id;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] opp(input logic [2:0] o);
    logic [2:0] r;
    case (o)
      P_N:     r = P_S;
      P_S:     r = P_N;
      P_E:     r = P_W;
      P_W:     r = P_E;
      default: r = P_L;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] rr_idx(input logic [2:0] base, input int unsigned step);
    return 3'((32'(base) + step) % PORTS);
  endfunction

  // An output may grant only if its receiver has room at the start of the cycle.
  always_comb begin
    for (int unsigned n = 0; n < NODES; n++) begin
      for (int unsigned o = 0; o < PORTS; o++) begin
        if (3'(o) == P_L)
          out_ok[n][o] = !sink_busy[n];
        else
          out_ok[n][o] = has_nb(4'(n), 3'(o)) &&
                         !buf_q[nb_node(4'(n), 3'(o))][opp(3'(o))].valid;
      end
    end
  end

  // Round-robin search starting at each output's pointer.
  always_comb begin
    for (int unsigned n = 0; n < NODES; n++) begin
      for (int unsigned o = 0; o < PORTS; o++) begin
        gnt_valid[n][o] = 1'b0;
        gnt_in[n][o]    = 3'd0;
        for (int unsigned k = 0; k < PORTS; k++) begin
          if (out_ok[n][o] && !gnt_valid[n][o] &&
              buf_q[n][rr_idx(ptr_q[n][o], k)].valid &&
              route(4'(n), buf_q[n][rr_idx(ptr_q[n][o], k)].dst) == 3'(o)) begin
            gnt_valid[n][o] = 1'b1;
            gnt_in[n][o]    = rr_idx(ptr_q[n][o], k);
          end
        end
      end
    end
  end

  // Fills only target empty buffers and clears only full ones, so update order is free.
  always_comb begin
    buf_d = buf_q;
    ptr_d = ptr_q;
    for (int unsigned n = 0; n < NODES; n++) begin
      eject_d[n] = gnt_valid[n][P_L] ? buf_q[n][gnt_in[n][P_L]] : '0;
      if (!buf_q[n][P_L].valid)
        buf_d[n][P_L] = '{valid: 1'b1, src: 4'(n), dst: k_in[n], zero: 7'd0,
                          a: a_in[n], b: b_in[n]};
      for (int unsigned o = 0; o < PORTS; o++) begin
        if (gnt_valid[n][o]) begin
          buf_d[n][gnt_in[n][o]] = '0;
          ptr_d[n][o]            = rr_idx(gnt_in[n][o], 1);
          if (3'(o) != P_L)
            buf_d[nb_node(4'(n), 3'(o))][opp(3'(o))] = buf_q[n][gnt_in[n][o]];
        end
      end
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      buf_q   <= '{default: '0};
      ptr_q   <= '{default: '0};
      eject_q <= '{default: '0};
    end else begin
      buf_q   <= buf_d;
      ptr_q   <= ptr_d;
      eject_q <= eject_d;
    end
  end

  assign buffer_out00 = buf_q[0][P_L].valid;
  assign buffer_out01 = buf_q[1][P_L].valid;
  assign buffer_out02 = buf_q[2][P_L].valid;
  assign buffer_out03 = buf_q[3][P_L].valid;
  assign buffer_out10 = buf_q[4][P_L].valid;
  assign buffer_out11 = buf_q[5][P_L].valid;
  assign buffer_out12 = buf_q[6][P_L].valid;
  assign buffer_out13 = buf_q[7][P_L].valid;
  assign buffer_out20 = buf_q[8][P_L].valid;
  assign buffer_out21 = buf_q[9][P_L].valid;
  assign buffer_out22 = buf_q[10][P_L].valid;
  assign buffer_out23 = buf_q[11][P_L].valid;
  assign buffer_out30 = buf_q[12][P_L].valid;
  assign buffer_out31 = buf_q[13][P_L].valid;
  assign buffer_out32 = buf_q[14][P_L].valid;
  assign buffer_out33 = buf_q[15][P_L].valid;

  assign router_out00 = BUS_WIDTH'(eject_q[0]);
  assign router_out01 = BUS_WIDTH'(eject_q[1]);
  assign router_out02 = BUS_WIDTH'(eject_q[2]);
  assign router_out03 = BUS_WIDTH'(eject_q[3]);
  assign router_out10 = BUS_WIDTH'(eject_q[4]);
  assign router_out11 = BUS_WIDTH'(eject_q[5]);
  assign router_out12 = BUS_WIDTH'(eject_q[6]);
  assign router_out13 = BUS_WIDTH'(eject_q[7]);
  assign router_out20 = BUS_WIDTH'(eject_q[8]);
  assign router_out21 = BUS_WIDTH'(eject_q[9]);
  assign router_out22 = BUS_WIDTH'(eject_q[10]);
  assign router_out23 = BUS_WIDTH'(eject_q[11]);
  assign router_out30 = BUS_WIDTH'(eject_q[12]);
  assign router_out31 = BUS_WIDTH'(eject_q[13]);
  assign router_out32 = BUS_WIDTH'(eject_q[14]);
  assign router_out33 = BUS_WIDTH'(eject_q[15]);

endmodule

// File: tb/tb_noc_nxn.sv
// Directed and scoreboarded bench for the 4x4 mesh NoC; node index = row*4 + col.
module tb_noc_nxn;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  a   [16];
  logic [7:0]  b   [16];
  logic [3:0]  k   [16];
  logic        bin [16];
  logic [31:0] ro  [16];
  logic        bo  [16];

  int checks = 0;
  int errors = 0;

  typedef logic [15:0] pay_q_t [$];
  pay_q_t sb [256];
  int     inj_cnt [16];
  int     ej_cnt  [16];
  int     ej_at6;
  int     seq6 [$];
  bit     log6 = 1'b0;

  noc_nxn #(.BUS_WIDTH(32)) dut (
    .clk1(clk), .rst(rst),
    .A00(a[0]),  .A01(a[1]),  .A02(a[2]),  .A03(a[3]),
    .A10(a[4]),  .A11(a[5]),  .A12(a[6]),  .A13(a[7]),
    .A20(a[8]),  .A21(a[9]),  .A22(a[10]), .A23(a[11]),
    .A30(a[12]), .A31(a[13]), .A32(a[14]), .A33(a[15]),
    .B00(b[0]),  .B01(b[1]),  .B02(b[2]),  .B03(b[3]),
    .B10(b[4]),  .B11(b[5]),  .B12(b[6]),  .B13(b[7]),
    .B20(b[8]),  .B21(b[9]),  .B22(b[10]), .B23(b[11]),
    .B30(b[12]), .B31(b[13]), .B32(b[14]), .B33(b[15]),
    .K00(k[0]),  .K01(k[1]),  .K02(k[2]),  .K03(k[3]),
    .K10(k[4]),  .K11(k[5]),  .K12(k[6]),  .K13(k[7]),
    .K20(k[8]),  .K21(k[9]),  .K22(k[10]), .K23(k[11]),
    .K30(k[12]), .K31(k[13]), .K32(k[14]), .K33(k[15]),
    .buffer_in00(bin[0]),  .buffer_in01(bin[1]),  .buffer_in02(bin[2]),  .buffer_in03(bin[3]),
    .buffer_in10(bin[4]),  .buffer_in11(bin[5]),  .buffer_in12(bin[6]),  .buffer_in13(bin[7]),
    .buffer_in20(bin[8]),  .buffer_in21(bin[9]),  .buffer_in22(bin[10]), .buffer_in23(bin[11]),
    .buffer_in30(bin[12]), .buffer_in31(bin[13]), .buffer_in32(bin[14]), .buffer_in33(bin[15]),
    .buffer_out00(bo[0]),  .buffer_out01(bo[1]),  .buffer_out02(bo[2]),  .buffer_out03(bo[3]),
    .buffer_out10(bo[4]),  .buffer_out11(bo[5]),  .buffer_out12(bo[6]),  .buffer_out13(bo[7]),
    .buffer_out20(bo[8]),  .buffer_out21(bo[9]),  .buffer_out22(bo[10]), .buffer_out23(bo[11]),
    .buffer_out30(bo[12]), .buffer_out31(bo[13]), .buffer_out32(bo[14]), .buffer_out33(bo[15]),
    .router_out00(ro[0]),  .router_out01(ro[1]),  .router_out02(ro[2]),  .router_out03(ro[3]),
    .router_out10(ro[4]),  .router_out11(ro[5]),  .router_out12(ro[6]),  .router_out13(ro[7]),
    .router_out20(ro[8]),  .router_out21(ro[9]),  .router_out22(ro[10]), .router_out23(ro[11]),
    .router_out30(ro[12]), .router_out31(ro[13]), .router_out32(ro[14]), .router_out33(ro[15])
  );

  // One clock: note which nodes capture on this edge, then check every ejection against the scoreboard.
  task automatic tick();
    logic        cap [16];
    int          src;
    logic [15:0] exp_pay;
    for (int n = 0; n < 16; n++) cap[n] = (rst === 1'b0) && (bo[n] === 1'b0);
    @(posedge clk);
    #1;
    for (int n = 0; n < 16; n++) begin
      if (cap[n]) begin
        sb[n*16 + int'(k[n])].push_back({a[n], b[n]});
        inj_cnt[n]++;
      end
    end
    for (int n = 0; n < 16; n++) begin
      if (ro[n] !== 32'h0) begin
        src = int'(ro[n][30:27]);
        checks++;
        if (ro[n][31] !== 1'b1 || ro[n][26:23] !== 4'(n) || ro[n][22:16] !== 7'd0 ||
            sb[src*16 + n].size() == 0) begin
          errors++;
          $display("FAIL eject_hdr node %0d: got %h, required valid flit addressed here with a pending flit from src %0d",
                   n, ro[n], src);
        end else begin
          exp_pay = sb[src*16 + n].pop_front();
          checks++;
          if (ro[n][15:0] !== exp_pay) begin
            errors++;
            $display("FAIL eject_payload node %0d src %0d: got %h, required %h", n, src, ro[n][15:0], exp_pay);
          end
          ej_cnt[src]++;
          if (n == 6) begin
            ej_at6++;
            if (log6) seq6.push_back(src);
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    foreach (sb[i]) sb[i].delete();
    for (int n = 0; n < 16; n++) begin
      inj_cnt[n] = 0;
      ej_cnt[n]  = 0;
    end
    ej_at6 = 0;
    seq6.delete();
    rst = 1'b0;
  endtask

  task automatic set_self();
    for (int n = 0; n < 16; n++) begin
      k[n]   = 4'(n);
      bin[n] = 1'b0;
    end
  endtask

  task automatic test_reset();
    for (int n = 0; n < 16; n++) begin
      a[n] = 8'($urandom); b[n] = 8'($urandom); k[n] = 4'($urandom); bin[n] = 1'($urandom);
    end
    rst = 1'b1;
    tick();
    tick();
    for (int n = 0; n < 16; n++) begin
      checks++;
      if (ro[n] !== 32'h0) begin
        errors++;
        $display("FAIL reset_router_out node %0d: got %h, required 0", n, ro[n]);
      end
      checks++;
      if (bo[n] !== 1'b0) begin
        errors++;
        $display("FAIL reset_buffer_out node %0d: got %b, required 0", n, bo[n]);
      end
    end
  endtask

  task automatic test_self_delivery();
    logic [31:0] exp;
    set_self();
    for (int n = 0; n < 16; n++) begin
      a[n] = 8'($urandom); b[n] = 8'($urandom);
    end
    a[0] = 8'h12; b[0] = 8'h34;
    do_reset();
    tick();
    checks++;
    if (bo[0] !== 1'b1 || ro[0] !== 32'h0) begin
      errors++;
      $display("FAIL self_capture: buffer_out00=%b router_out00=%h, required 1 and 0", bo[0], ro[0]);
    end
    tick();
    checks++;
    if (ro[0] !== 32'h8000_1234 || bo[0] !== 1'b0) begin
      errors++;
      $display("FAIL self_first: router_out00=%h buffer_out00=%b, required 80001234 and 0", ro[0], bo[0]);
    end
    for (int n = 1; n < 16; n++) begin
      exp = {1'b1, 4'(n), 4'(n), 7'd0, a[n], b[n]};
      checks++;
      if (ro[n] !== exp) begin
        errors++;
        $display("FAIL self_node node %0d: got %h, required %h", n, ro[n], exp);
      end
    end
    tick();
    checks++;
    if (ro[0] !== 32'h0 || bo[0] !== 1'b1) begin
      errors++;
      $display("FAIL self_gap: router_out00=%h buffer_out00=%b, required 0 and 1", ro[0], bo[0]);
    end
    tick();
    checks++;
    if (ro[0] !== 32'h8000_1234) begin
      errors++;
      $display("FAIL self_second: router_out00=%h, required 80001234", ro[0]);
    end
  endtask

  task automatic test_corner();
    bit found = 1'b0;
    set_self();
    for (int n = 0; n < 16; n++) begin
      a[n] = 8'($urandom); b[n] = 8'($urandom);
    end
    k[0] = 4'hF; a[0] = 8'hAB; b[0] = 8'hCD;
    do_reset();
    tick();
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (ro[15] === 32'h8780_ABCD) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL corner_arrival: router_out33 never showed 8780abcd within 10 cycles (last %h)", ro[15]);
    end
    k[0] = 4'h0;
    repeat (40) tick();
    checks++;
    if (sb[15].size() != 0) begin
      errors++;
      $display("FAIL corner_drain: %0d flits 00->33 undelivered, required 0", sb[15].size());
    end
  endtask

  task automatic test_hotspot();
    int stuck_bad = 0;
    for (int n = 0; n < 16; n++) begin
      a[n] = 8'($urandom); b[n] = 8'($urandom); k[n] = 4'h6; bin[n] = 1'b0;
    end
    bin[6] = 1'b1;
    do_reset();
    repeat (30) begin
      tick();
      if (ro[6] !== 32'h0) stuck_bad++;
    end
    checks++;
    if (stuck_bad != 0) begin
      errors++;
      $display("FAIL hotspot_stall: router_out12 nonzero in %0d stalled cycles, required 0", stuck_bad);
    end
    for (int n = 0; n < 16; n++) begin
      checks++;
      if (bo[n] !== 1'b1) begin
        errors++;
        $display("FAIL hotspot_backpressure node %0d: buffer_out=%b, required 1", n, bo[n]);
      end
    end
    bin[6] = 1'b0;
    repeat (60) tick();
    checks++;
    if (ej_at6 == 0) begin
      errors++;
      $display("FAIL hotspot_resume: %0d ejections at node 12 after release, required >0", ej_at6);
    end
    set_self();
    repeat (300) tick();
    for (int s = 0; s < 16; s++) begin
      if (s != 6) begin
        checks++;
        if (sb[s*16 + 6].size() != 0) begin
          errors++;
          $display("FAIL hotspot_count src %0d: %0d flits undelivered (injected %0d ejected %0d), required 0",
                   s, sb[s*16 + 6].size(), inj_cnt[s], ej_cnt[s]);
        end
      end
    end
  endtask

  task automatic test_fairness();
    int srcs [3] = '{2, 5, 7};
    int gap;
    int maxgap;
    set_self();
    for (int n = 0; n < 16; n++) begin
      a[n] = 8'($urandom); b[n] = 8'($urandom);
    end
    k[2] = 4'h6; k[5] = 4'h6; k[7] = 4'h6;
    do_reset();
    log6 = 1'b1;
    repeat (200) tick();
    log6 = 1'b0;
    checks++;
    if (seq6.size() < 30) begin
      errors++;
      $display("FAIL fair_volume: %0d ejections at node 12, required >=30", seq6.size());
    end
    for (int j = 0; j < 3; j++) begin
      gap = 0;
      maxgap = 0;
      foreach (seq6[i]) begin
        if (seq6[i] == srcs[j]) gap = 0;
        else begin
          gap++;
          if (gap > maxgap) maxgap = gap;
        end
      end
      checks++;
      if (maxgap >= 15) begin
        errors++;
        $display("FAIL fair_src %0d: longest run without it %0d ejections, required <15", srcs[j], maxgap);
      end
    end
  endtask

  task automatic test_random();
    int leftover = 0;
    int total = 0;
    do_reset();
    repeat (1000) begin
      for (int n = 0; n < 16; n++) begin
        a[n] = 8'($urandom); b[n] = 8'($urandom); k[n] = 4'($urandom);
        bin[n] = ($urandom_range(0, 7) == 0);
      end
      tick();
    end
    set_self();
    repeat (300) tick();
    for (int s = 0; s < 16; s++) begin
      total += ej_cnt[s];
      for (int d = 0; d < 16; d++)
        if (s != d) leftover += sb[s*16 + d].size();
    end
    checks++;
    if (leftover != 0) begin
      errors++;
      $display("FAIL random_drain: %0d captured flits never ejected, required 0", leftover);
    end
    checks++;
    if (total < 200) begin
      errors++;
      $display("FAIL random_volume: %0d flits ejected, required >=200", total);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int n = 0; n < 16; n++) begin
      a[n] = 8'h0; b[n] = 8'h0; k[n] = 4'h0; bin[n] = 1'b0;
    end
    test_reset();
    test_self_delivery();
    test_corner();
    test_hotspot();
    test_fairness();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
